mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_lane.sv | 56 +++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the fetch/load-store memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    // Access size code to byte count; the reserved code 11 behaves as a word.
    function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: len_bytes = CNT_W'(1);
            LEN_HALF: len_bytes = CNT_W'(2);
            default:  len_bytes = CNT_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_lane.sv
// Load byte assembly: shifts RAM bytes in from the top, right-aligns and extends.
// Sign extension is present only when MEM_ARB_SEXT_EN is defined.
module mem_arb_lane
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              last,
    input  logic [BYTE_W-1:0] din,
    input  logic [CNT_W-1:0]  n,
    input  logic              sgn,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] ext;
    logic [5:0]        shamt;

    // Bytes enter at the top, so after n captures they sit in the upper n lanes.
    always_comb begin
        merged  = {din, shreg[DATA_W-1:BYTE_W]};
        shamt   = {3'(3'd4 - n), 3'b000};
        aligned = merged >> shamt;
        ext     = aligned;
`ifdef MEM_ARB_SEXT_EN
        if (sgn) begin
            case (n)
                CNT_W'(1): ext = {{24{aligned[7]}}, aligned[7:0]};
                CNT_W'(2): ext = {{16{aligned[15]}}, aligned[15:0]};
                default:   ext = aligned;
            endcase
        end
`endif
    end

`ifndef MEM_ARB_SEXT_EN
    logic unused_sgn;
    assign unused_sgn = sgn;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            rdata <= '0;
        end else if (capture) begin
            shreg <= merged;
            if (last) begin
                rdata <= ext;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port byte RAM arbiter: load/store port preempts instruction fetch.
// Define MEM_ARB_SEXT_EN to enable sign-extended byte/half loads.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_addr_i,
    output logic [BYTE_W-1:0] if_data_o,
    output logic              if_pause_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_len_i,
    input  logic              mem_signed_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    input  logic [BYTE_W-1:0] ram_din_i,
    output logic [BYTE_W-1:0] ram_dout_o,
    output logic [DATA_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   n_q;
    logic [DATA_W-1:0]  base_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               sgn_q;
    logic               lane_capture;
    logic               lane_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            n_q     <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            sgn_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req_i) begin
                        base_q  <= mem_addr_i;
                        wdata_q <= mem_wdata_i;
                        sgn_q   <= mem_signed_i;
                        n_q     <= len_bytes(mem_len_i);
                        cnt     <= '0;
                        state   <= mem_we_i ? S_WR : S_RD;
                    end
                end
                // One extra RD cycle collects the last byte after its address.
                S_RD: begin
                    if (cnt == n_q) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WR: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == n_q - CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM port steering; memory access takes the port in the cycle it is requested.
    always_comb begin
        ram_a_o    = if_addr_i;
        ram_wr_o   = 1'b0;
        ram_dout_o = '0;
        if_pause_o = 1'b1;
        mem_done_o = 1'b0;
        case (state)
            S_IDLE: begin
                if_pause_o = mem_req_i;
                if (mem_req_i) begin
                    ram_a_o = mem_addr_i;
                end
            end
            S_RD: ram_a_o = base_q + DATA_W'(cnt);
            S_WR: begin
                ram_a_o    = base_q + DATA_W'(cnt);
                ram_wr_o   = 1'b1;
                ram_dout_o = wdata_q[{cnt[1:0], 3'b000} +: BYTE_W];
            end
            S_DONE:  mem_done_o = 1'b1;
            default: mem_done_o = 1'b0;
        endcase
    end

    assign if_data_o    = ram_din_i;
    assign lane_capture = (state == S_RD) && (cnt != '0);
    assign lane_last    = (cnt == n_q);

    mem_arb_lane u_lane (
        .clk     (clk),
        .rst     (rst),
        .capture (lane_capture),
        .last    (lane_last),
        .din     (ram_din_i),
        .n       (n_q),
        .sgn     (sgn_q),
        .rdata   (mem_rdata_o)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous byte RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_addr_i = '0;
    logic [7:0]  if_data_o;
    logic        if_pause_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [1:0]  mem_len_i = '0;
    logic        mem_signed_i = 1'b0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic [7:0]  ram_din_i;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;

    logic [7:0]  ram [0:4095];
    logic [7:0]  ram_q = '0;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MEM_ARB_SEXT_EN
    localparam logic [31:0] EXP_SB = 32'hFFFFFF80;
    localparam logic [31:0] EXP_SH = 32'hFFFF8001;
`else
    localparam logic [31:0] EXP_SB = 32'h00000080;
    localparam logic [31:0] EXP_SH = 32'h00008001;
`endif

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_addr_i    (if_addr_i),
        .if_data_o    (if_data_o),
        .if_pause_o   (if_pause_o),
        .mem_req_i    (mem_req_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_len_i    (mem_len_i),
        .mem_signed_i (mem_signed_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_rdata_o  (mem_rdata_o),
        .mem_done_o   (mem_done_o),
        .ram_din_i    (ram_din_i),
        .ram_dout_o   (ram_dout_o),
        .ram_a_o      (ram_a_o),
        .ram_wr_o     (ram_wr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_a_o[11:0]] <= ram_dout_o;
        ram_q <= ram[ram_a_o[11:0]];
    end
    assign ram_din_i = ram_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request now (IDLE), then run until the done pulse or a 20-cycle bound.
    task automatic access(input bit we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wd, input bit sg,
                          output int cyc, output int wrs, output bit pause_ok);
        mem_req_i    = 1'b1;
        mem_we_i     = we;
        mem_len_i    = len;
        mem_addr_i   = addr;
        mem_wdata_i  = wd;
        mem_signed_i = sg;
        #1;
        check("accept_pause", 32'(if_pause_o), 32'd1);
        check("accept_addr", ram_a_o, addr);
        cyc = 0;
        wrs = 0;
        pause_ok = 1'b1;
        while (1) begin
            step();
            cyc++;
            if (mem_done_o) break;
            if (!if_pause_o) pause_ok = 1'b0;
            if (ram_wr_o) wrs++;
            if (cyc >= 20) break;
        end
        mem_req_i = 1'b0;
    endtask

    initial begin
        int  cyc;
        int  wrs;
        bit  pok;
        bit  saw_done;

        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13;
        ram[12'h200] = 8'h78; ram[12'h201] = 8'h56; ram[12'h202] = 8'h34; ram[12'h203] = 8'h12;
        ram[12'h400] = 8'h80;
        ram[12'h500] = 8'h01; ram[12'h501] = 8'h80;
        ram[12'hFFF] = 8'hAA; ram[12'h000] = 8'hBB; ram[12'h001] = 8'hCC; ram[12'h002] = 8'hDD;

        // Reset state
        #2;
        check("rst_done", 32'(mem_done_o), 32'd0);
        check("rst_rdata", mem_rdata_o, 32'd0);
        check("rst_wr", 32'(ram_wr_o), 32'd0);
        check("rst_dout", 32'(ram_dout_o), 32'd0);
        check("rst_pause", 32'(if_pause_o), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Fetch path in IDLE
        if_addr_i = 32'h100;
        #1;
        check("fetch_addr", ram_a_o, 32'h100);
        check("fetch_pause", 32'(if_pause_o), 32'd0);
        step();
        check("fetch_data", 32'(if_data_o), 32'h13);

        // Word load preempting fetch
        if_addr_i = 32'h104;
        access(1'b0, 2'b10, 32'h200, 32'h0, 1'b0, cyc, wrs, pok);
        check("ld_word_cyc", 32'(cyc), 32'd6);
        check("ld_word_pause", 32'(pok), 32'd1);
        check("ld_word_rdata", mem_rdata_o, 32'h12345678);
        step();
        check("after_done_pulse", 32'(mem_done_o), 32'd0);
        check("fetch_resume_addr", ram_a_o, 32'h104);
        check("fetch_resume_pause", 32'(if_pause_o), 32'd0);

        // Half store
        access(1'b1, 2'b01, 32'h300, 32'h0000BEEF, 1'b0, cyc, wrs, pok);
        check("st_half_cyc", 32'(cyc), 32'd3);
        check("st_half_wrs", 32'(wrs), 32'd2);
        check("st_half_wr_done", 32'(ram_wr_o), 32'd0);
        step();
        check("st_half_b0", 32'(ram[12'h300]), 32'hEF);
        check("st_half_b1", 32'(ram[12'h301]), 32'hBE);
        check("rdata_hold", mem_rdata_o, 32'h12345678);

        // Signed byte and half loads
        access(1'b0, 2'b00, 32'h400, 32'h0, 1'b1, cyc, wrs, pok);
        check("ld_sbyte_cyc", 32'(cyc), 32'd3);
        check("ld_sbyte_rdata", mem_rdata_o, EXP_SB);
        step();
        access(1'b0, 2'b01, 32'h500, 32'h0, 1'b1, cyc, wrs, pok);
        check("ld_shalf_cyc", 32'(cyc), 32'd4);
        check("ld_shalf_rdata", mem_rdata_o, EXP_SH);
        step();
        access(1'b0, 2'b00, 32'h400, 32'h0, 1'b0, cyc, wrs, pok);
        check("ld_ubyte_rdata", mem_rdata_o, 32'h00000080);
        step();

        // Word load wrapping across 2^32
        access(1'b0, 2'b10, 32'hFFFFFFFF, 32'h0, 1'b0, cyc, wrs, pok);
        check("ld_wrap_rdata", mem_rdata_o, 32'hDDCCBBAA);
        step();

        // Reserved length code acts as a word store
        access(1'b1, 2'b11, 32'h600, 32'h11223344, 1'b0, cyc, wrs, pok);
        check("st_len3_cyc", 32'(cyc), 32'd5);
        check("st_len3_wrs", 32'(wrs), 32'd4);
        step();
        check("st_len3_b0", 32'(ram[12'h600]), 32'h44);
        check("st_len3_b3", 32'(ram[12'h603]), 32'h11);

        // Asynchronous reset during RD with cnt = 2
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_len_i  = 2'b10;
        mem_addr_i = 32'h200;
        step();
        step();
        step();
        check("mid_rd_addr", ram_a_o, 32'h202);
        mem_req_i = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_rdata", mem_rdata_o, 32'd0);
        check("arst_pause", 32'(if_pause_o), 32'd0);
        check("arst_done", 32'(mem_done_o), 32'd0);
        check("arst_addr", ram_a_o, 32'h104);
        step();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mem_done_o) saw_done = 1'b1;
        end
        check("arst_no_done", 32'(saw_done), 32'd0);
        check("arst_idle_pause", 32'(if_pause_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
